// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the instruction-fetch stage:
//   - BUBBLE_INSTR_DEFAULT : word presented on IF/ID when nothing valid is held
//   - WORD_BYTES           : byte stride between sequential instruction words
//   - fetch_state_e        : fetch FSM state encoding (IDLE / WAIT / DROP)
//   - fetch_entry_t        : prefetch buffer entry {instr, pc_plus_four}
//   - next_word_addr()     : PC + WORD_BYTES, modulo 2^32
// -----------------------------------------------------------------------------
package arm_pkg;

  localparam logic [31:0] BUBBLE_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES           = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    WAIT = 2'd1,  // request outstanding, its data will be kept
    DROP = 2'd2   // request outstanding, its data is wrong-path and discarded
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_four;
  } fetch_entry_t;

  // Sequential word address; wraps naturally past 32'hFFFF_FFFC.
  function automatic logic [31:0] next_word_addr(input logic [31:0] pc);
    return pc + WORD_BYTES;
  endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Prefetch buffer between the instruction-memory handshake and the IF/ID
// register. DEPTH entries (power of two), each a fetch_entry_t.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the buffer)
//   clear         : synchronous flush, takes priority over push/pop
//   push, wdata   : write an entry (ignored when full unless popping too)
//   pop, rdata    : rdata is the current head; pop advances it (ignored when empty)
//   full, empty   : occupancy flags
//   count         : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  // Pointer and occupancy next-state; clear wins over everything.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A push into a full buffer is accepted only when the head leaves the same edge.
    do_push  = push && ((count_q != FULL_COUNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1'b1);
        2'b01:   count_d = count_q - (AW+1)'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer / count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful behind the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Owns the fetch PC, issues word fetches over a
// req/ack handshake (one outstanding request max), buffers returned words in
// fetch_fifo and presents the head on registered IF/ID outputs.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   freeze_in           : decode hazard stall; IF/ID outputs and FIFO head hold
//   branch_taken_in     : one-cycle redirect pulse (overrides freeze)
//   branch_address_in   : redirect target, word aligned
//   imem_req_out        : registered fetch request
//   imem_addr_out       : registered fetch address, stable while req is high
//   imem_ack_in         : response strobe, imem_rdata_in valid this cycle
//   imem_rdata_in       : fetched word
//   instruction_out     : IF/ID instruction (BUBBLE_INSTR when not valid)
//   pc_plus_four_out    : IF/ID PC of instruction_out plus 4
//   instr_valid_out     : instruction_out is a real fetched word
// -----------------------------------------------------------------------------
module if_stage
  import arm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = BUBBLE_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_address_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_plus_four_out,
  output logic        instr_valid_out
);

  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;

  logic         ack_s;
  logic         fifo_push, fifo_pop, fifo_clear;
  logic         fifo_full, fifo_empty;
  logic [AW:0]  fifo_count;
  logic [AW:0]  count_after;
  fetch_entry_t fifo_wdata, fifo_head;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Fetch FSM, FIFO control and IF/ID next-state.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    req_d         = req_q;
    addr_d        = addr_q;
    instr_d       = instr_q;
    pc4_d         = pc4_q;
    valid_d       = valid_q;
    fifo_clear    = 1'b0;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_wdata    = '{instr: imem_rdata_in, pc_plus_four: next_word_addr(addr_q)};

    // An ack only means something while a request is actually out.
    ack_s = req_q && imem_ack_in;

    // IF/ID register: branch flushes, freeze holds, otherwise drain the head.
    if (branch_taken_in) begin
      fifo_clear = 1'b1;
      instr_d    = BUBBLE_INSTR;
      valid_d    = 1'b0;
    end else if (freeze_in) begin
      instr_d = instr_q;
      valid_d = valid_q;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      instr_d  = fifo_head.instr;
      pc4_d    = fifo_head.pc_plus_four;
      valid_d  = 1'b1;
    end else begin
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
    end

    // Only right-path data in WAIT is kept; branch-cycle data is wrong-path.
    fifo_push = !branch_taken_in && (state_q == WAIT) && ack_s;

    // Occupancy after this edge, used to decide whether a back-to-back issue fits.
    case ({fifo_push, fifo_pop})
      2'b10:   count_after = fifo_count + (AW+1)'(1'b1);
      2'b01:   count_after = fifo_count - (AW+1)'(1'b1);
      default: count_after = fifo_count;
    endcase

    if (branch_taken_in) begin
      if (req_q && !imem_ack_in) begin
        // Cannot withdraw the live request: remember the target, eat the reply.
        redirect_pc_d = branch_address_in;
        state_d       = DROP;
      end else begin
        req_d      = 1'b1;
        addr_d     = branch_address_in;
        fetch_pc_d = next_word_addr(branch_address_in);
        state_d    = WAIT;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_full) begin
            req_d      = 1'b1;
            addr_d     = fetch_pc_q;
            fetch_pc_d = next_word_addr(fetch_pc_q);
            state_d    = WAIT;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
        WAIT: begin
          if (ack_s) begin
            if (count_after < FULL_COUNT) begin
              req_d      = 1'b1;
              addr_d     = fetch_pc_q;
              fetch_pc_d = next_word_addr(fetch_pc_q);
              state_d    = WAIT;
            end else begin
              req_d   = 1'b0;
              state_d = IDLE;
            end
          end else begin
            state_d = WAIT;
          end
        end
        DROP: begin
          if (ack_s) begin
            req_d      = 1'b1;
            addr_d     = redirect_pc_q;
            fetch_pc_d = next_word_addr(redirect_pc_q);
            state_d    = WAIT;
          end else begin
            state_d = DROP;
          end
        end
        default: begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, handshake and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      req_q         <= 1'b0;
      addr_q        <= RESET_PC;
      instr_q       <= BUBBLE_INSTR;
      pc4_q         <= 32'h0000_0000;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      instr_q       <= instr_d;
      pc4_q         <= pc4_d;
      valid_q       <= valid_d;
    end
  end

  assign imem_req_out     = req_q;
  assign imem_addr_out    = addr_q;
  assign instruction_out  = instr_q;
  assign pc_plus_four_out = pc4_q;
  assign instr_valid_out  = valid_q;

endmodule
